sd_scoreboard_arbiter: RTL and testbench

Request arbiter and response router placed directly upstream of the scoreboard FSM. It merges read/write/masked-write requests from `clients` independent requesters onto the single `ip_*` request port. Each transaction is tagged with the requester index as the transaction ID. Read results arriving on the `ic_*` port are steered back to the requester named by `ic_txid`.

---
 rtl/sd_scoreboard_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_sd_scoreboard_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_scoreboard_arbiter.sv
// -----------------------------------------------------------------------------
// sd_scoreboard_arbiter
//
// Request arbiter and response router in front of the scoreboard FSM.
// Merges read / write / masked-write requests from `clients` requesters onto a
// single ip_* request port. The requester index travels with the request as the
// transaction ID. Read results on the ic_* port are steered back to the
// requester named by ic_txid.
//
// Arbitration mode is chosen at build time:
//   SDLIB_SCBARB_RR_EN defined   : round-robin, starting from pointer `ptr`
//   SDLIB_SCBARB_RR_EN undefined : fixed priority, lowest index wins
//
// Parameters:
//   clients  number of requesters (clients <= 2**txid_sz)
//   width    record width in bits
//   items    number of scoreboard items
//   txid_sz  transaction ID width
//   asz      item address width
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   p_srdy/p_drdy    per-requester request handshake
//   p_req_type       per-requester request type (0 = read, 1 = write)
//   p_mask, p_data   packed per-requester write mask / data ([i*width +: width])
//   p_itemid         packed per-requester item IDs ([i*asz +: asz])
//   ip_*             merged request port to the scoreboard
//   ic_*             read-result port from the scoreboard
//   c_srdy/c_drdy    per-requester result handshake
//   c_data           result data, broadcast to all requesters
// -----------------------------------------------------------------------------
module sd_scoreboard_arbiter #(
  parameter int clients = 4,
  parameter int width   = 8,
  parameter int items   = 64,
  parameter int txid_sz = 2,
  parameter int asz     = $clog2(items)
) (
  input  logic                     clk,
  input  logic                     reset,
  // requester side
  input  logic [clients-1:0]       p_srdy,
  output logic [clients-1:0]       p_drdy,
  input  logic [clients-1:0]       p_req_type,
  input  logic [clients*width-1:0] p_mask,
  input  logic [clients*width-1:0] p_data,
  input  logic [clients*asz-1:0]   p_itemid,
  // scoreboard request side
  output logic                     ip_srdy,
  input  logic                     ip_drdy,
  output logic                     ip_req_type,
  output logic [txid_sz-1:0]       ip_txid,
  output logic [width-1:0]         ip_mask,
  output logic [width-1:0]         ip_data,
  output logic [asz-1:0]           ip_itemid,
  // scoreboard result side
  input  logic                     ic_srdy,
  output logic                     ic_drdy,
  input  logic [txid_sz-1:0]       ic_txid,
  input  logic [width-1:0]         ic_data,
  // requester result side
  output logic [clients-1:0]       c_srdy,
  input  logic [clients-1:0]       c_drdy,
  output logic [width-1:0]         c_data
);

  typedef enum logic {
    s_open,
    s_locked
  } state_t;

  state_t             state;
  logic [txid_sz-1:0] gnt;      // requester holding the lock
  logic [txid_sz-1:0] win;      // arbitration winner this cycle (open state)
  logic [txid_sz-1:0] sel;      // requester currently driving ip_*
  logic               any_req;
  logic               sel_req;  // p_srdy of the selected requester
  logic               accept;   // request handed to the scoreboard this cycle
  logic               ic_drdy_raw;

`ifdef SDLIB_SCBARB_RR_EN
  logic [txid_sz-1:0] ptr;      // next preferred requester

  // First requester with p_srdy set, searching start, start+1, ... with wrap.
  // When nobody requests, the result is `start`, whose p_srdy is then 0.
  function automatic logic [txid_sz-1:0] pick_rr(input logic [clients-1:0] req,
                                                 input logic [txid_sz-1:0] start);
    logic [txid_sz-1:0] res;
    logic               found;
    int                 idx;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < clients; k++) begin
      idx = (int'(start) + k) % clients;
      if (!found && req[idx]) begin
        res   = txid_sz'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [txid_sz-1:0] next_ptr(input logic [txid_sz-1:0] idx);
    return txid_sz'((int'(idx) + 1) % clients);
  endfunction
`else
  // Lowest-index requester with p_srdy set; 0 when nobody requests.
  function automatic logic [txid_sz-1:0] pick_fixed(input logic [clients-1:0] req);
    logic [txid_sz-1:0] res;
    res = '0;
    for (int i = clients - 1; i >= 0; i--) begin
      if (req[i]) res = txid_sz'(i);
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Request path (combinational, zero latency)
  // ---------------------------------------------------------------------------
  assign any_req = |p_srdy;

  always_comb begin
`ifdef SDLIB_SCBARB_RR_EN
    win = pick_rr(p_srdy, ptr);
`else
    win = pick_fixed(p_srdy);
`endif
  end

  // While locked, other requesters are ignored so the granted request stays
  // stable across the scoreboard's two-cycle read-modify-write path.
  assign sel = (state == s_locked) ? gnt : win;

  // NOTE: every output of this block gets a default first, so no path through
  // the loop can leave a signal unassigned and infer a latch.
  always_comb begin
    sel_req     = 1'b0;
    ip_req_type = 1'b0;
    ip_mask     = '0;
    ip_data     = '0;
    ip_itemid   = '0;
    for (int i = 0; i < clients; i++) begin
      if (sel == txid_sz'(i)) begin
        sel_req     = p_srdy[i];
        ip_req_type = p_req_type[i];
        ip_mask     = p_mask[i*width +: width];
        ip_data     = p_data[i*width +: width];
        ip_itemid   = p_itemid[i*asz +: asz];
      end
    end
    // Data fields read as zero while reset is asserted.
    if (reset) begin
      ip_req_type = 1'b0;
      ip_mask     = '0;
      ip_data     = '0;
      ip_itemid   = '0;
    end
  end

  // In the open state the winner always has p_srdy set when anyone requests,
  // so sel_req doubles as "any request"; while locked it tracks only the
  // grant holder, and a dropped p_srdy (protocol error) simply idles the port.
  assign ip_srdy = !reset && sel_req;
  assign ip_txid = reset ? '0 : sel;

  // ip_drdy only counts while a request is actually being offered.
  assign accept = ip_srdy && ip_drdy;

  always_comb begin
    p_drdy = '0;
    for (int i = 0; i < clients; i++) begin
      p_drdy[i] = accept && (sel == txid_sz'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= s_open;
      gnt   <= '0;
`ifdef SDLIB_SCBARB_RR_EN
      ptr   <= '0;
`endif
    end else begin
      unique case (state)
        s_open: begin
          // Accepted in the same cycle: no lock needed.
          if (any_req && !ip_drdy) begin
            gnt   <= win;
            state <= s_locked;
          end
        end
        s_locked: begin
          if (accept) state <= s_open;
        end
        default: state <= s_open;
      endcase
`ifdef SDLIB_SCBARB_RR_EN
      if (accept) ptr <= next_ptr(sel);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Response path (combinational, zero latency)
  // ---------------------------------------------------------------------------
  // A transaction ID that names no requester is acknowledged and dropped.
  always_comb begin
    c_srdy      = '0;
    ic_drdy_raw = 1'b1;
    for (int i = 0; i < clients; i++) begin
      if (ic_txid == txid_sz'(i)) begin
        c_srdy[i]   = ic_srdy && !reset;
        ic_drdy_raw = c_drdy[i];
      end
    end
  end

  assign ic_drdy = !reset && ic_drdy_raw;
  assign c_data  = ic_data;

endmodule

// File: tb/tb_sd_scoreboard_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_scoreboard_arbiter
//
// Directed bench for sd_scoreboard_arbiter. A table of single-cycle vectors
// covers the basic request/response behaviour; hand-written sequences cover the
// multi-cycle cases (masked-write lock, arbitration order, result backpressure,
// out-of-range transaction ID on a 3-client build, reset during a lock).
// Expected arbitration results follow SDLIB_SCBARB_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_sd_scoreboard_arbiter;

  localparam int clients = 4;
  localparam int width   = 8;
  localparam int items   = 64;
  localparam int txid_sz = 2;
  localparam int asz     = 6;

  logic                     clk;
  logic                     reset;
  logic [clients-1:0]       p_srdy;
  logic [clients-1:0]       p_drdy;
  logic [clients-1:0]       p_req_type;
  logic [clients*width-1:0] p_mask;
  logic [clients*width-1:0] p_data;
  logic [clients*asz-1:0]   p_itemid;
  logic                     ip_srdy;
  logic                     ip_drdy;
  logic                     ip_req_type;
  logic [txid_sz-1:0]       ip_txid;
  logic [width-1:0]         ip_mask;
  logic [width-1:0]         ip_data;
  logic [asz-1:0]           ip_itemid;
  logic                     ic_srdy;
  logic                     ic_drdy;
  logic [txid_sz-1:0]       ic_txid;
  logic [width-1:0]         ic_data;
  logic [clients-1:0]       c_srdy;
  logic [clients-1:0]       c_drdy;
  logic [width-1:0]         c_data;

  // 3-client instance, used for the out-of-range transaction ID case
  logic [2:0]       u3_p_srdy;
  logic [2:0]       u3_p_drdy;
  logic [2:0]       u3_p_req_type;
  logic [3*width-1:0] u3_p_mask;
  logic [3*width-1:0] u3_p_data;
  logic [3*asz-1:0] u3_p_itemid;
  logic             u3_ip_srdy;
  logic             u3_ip_req_type;
  logic [1:0]       u3_ip_txid;
  logic [width-1:0] u3_ip_mask;
  logic [width-1:0] u3_ip_data;
  logic [asz-1:0]   u3_ip_itemid;
  logic             u3_ic_srdy;
  logic             u3_ic_drdy;
  logic [1:0]       u3_ic_txid;
  logic [2:0]       u3_c_srdy;
  logic [2:0]       u3_c_drdy;
  logic [width-1:0] u3_c_data;

  sd_scoreboard_arbiter #(
    .clients(clients), .width(width), .items(items), .txid_sz(txid_sz)
  ) dut (
    .clk(clk), .reset(reset),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_req_type(p_req_type),
    .p_mask(p_mask), .p_data(p_data), .p_itemid(p_itemid),
    .ip_srdy(ip_srdy), .ip_drdy(ip_drdy), .ip_req_type(ip_req_type),
    .ip_txid(ip_txid), .ip_mask(ip_mask), .ip_data(ip_data), .ip_itemid(ip_itemid),
    .ic_srdy(ic_srdy), .ic_drdy(ic_drdy), .ic_txid(ic_txid), .ic_data(ic_data),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data)
  );

  sd_scoreboard_arbiter #(
    .clients(3), .width(width), .items(items), .txid_sz(txid_sz)
  ) u3 (
    .clk(clk), .reset(reset),
    .p_srdy(u3_p_srdy), .p_drdy(u3_p_drdy), .p_req_type(u3_p_req_type),
    .p_mask(u3_p_mask), .p_data(u3_p_data), .p_itemid(u3_p_itemid),
    .ip_srdy(u3_ip_srdy), .ip_drdy(ip_drdy), .ip_req_type(u3_ip_req_type),
    .ip_txid(u3_ip_txid), .ip_mask(u3_ip_mask), .ip_data(u3_ip_data),
    .ip_itemid(u3_ip_itemid),
    .ic_srdy(u3_ic_srdy), .ic_drdy(u3_ic_drdy), .ic_txid(u3_ic_txid),
    .ic_data(ic_data),
    .c_srdy(u3_c_srdy), .c_drdy(u3_c_drdy), .c_data(u3_c_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at
  // the falling edge, then time advances past the next rising edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    p_srdy  = '0;
    ip_drdy = 1'b0;
    next_cycle();
    reset   = 1'b0;
  endtask

  // Expected request fields of requester i, from the stimulus set up below.
  logic [3:0] req_type_v;
  function automatic logic [7:0] exp_data(input logic [1:0] i);
    return 8'h10 + 8'(i);
  endfunction
  function automatic logic [5:0] exp_itemid(input logic [1:0] i);
    return 6'(i) * 6'd5 + 6'd1;
  endfunction

  typedef struct {
    logic [3:0] p_srdy;
    logic       ip_drdy;
    logic       ic_srdy;
    logic [1:0] ic_txid;
    logic [7:0] ic_data;
    logic [3:0] c_drdy;
    logic       e_ip_srdy;
    logic [3:0] e_p_drdy;
    logic [1:0] e_txid;
    logic [3:0] e_c_srdy;
    logic       e_ic_drdy;
  } vec_t;

  vec_t vecs[9];
  logic [1:0] exp_id;

  initial begin
    // Vectors run back to back from reset; every request is accepted on
    // arrival, so the arbiter never locks within the table.
    vecs[0] = '{4'b0001, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0100, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b0};
    vecs[2] = '{4'b1000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b0};
    vecs[3] = '{4'b0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b1};
    vecs[4] = '{4'b0000, 1'b0, 1'b1, 2'd1, 8'h3C, 4'b0010, 1'b0, 4'b0000, 2'd0, 4'b0010, 1'b1};
    vecs[5] = '{4'b0000, 1'b0, 1'b1, 2'd2, 8'hC3, 4'b1011, 1'b0, 4'b0000, 2'd0, 4'b0100, 1'b0};
    vecs[6] = '{4'b0000, 1'b0, 1'b0, 2'd0, 8'h77, 4'b0001, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b1};
    vecs[7] = '{4'b0011, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0};
`ifdef SDLIB_SCBARB_RR_EN
    // pointer is 1 after client 0 was accepted in the previous vector
    vecs[8] = '{4'b0011, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b0};
`else
    vecs[8] = '{4'b0011, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0};
`endif

    req_type_v = 4'b0101;
    p_req_type = req_type_v;
    for (int i = 0; i < clients; i++) begin
      p_data[i*width +: width] = exp_data(2'(i));
      p_mask[i*width +: width] = 8'hFF;
      p_itemid[i*asz +: asz]   = exp_itemid(2'(i));
    end
    u3_p_srdy     = '0;
    u3_p_req_type = '0;
    u3_p_mask     = '0;
    u3_p_data     = '0;
    u3_p_itemid   = '0;
    u3_ic_srdy    = 1'b0;
    u3_ic_txid    = '0;
    u3_c_drdy     = '0;

    // ---------------- reset state, with every input active ----------------
    reset   = 1'b1;
    p_srdy  = 4'b1111;
    ip_drdy = 1'b1;
    ic_srdy = 1'b1;
    ic_txid = 2'd0;
    ic_data = 8'h5A;
    c_drdy  = 4'b1111;
    @(negedge clk);
    check("rst ip_srdy", 32'(ip_srdy), 32'd0);
    check("rst p_drdy", 32'(p_drdy), 32'd0);
    check("rst c_srdy", 32'(c_srdy), 32'd0);
    check("rst ic_drdy", 32'(ic_drdy), 32'd0);
    check("rst ip_data", 32'(ip_data), 32'd0);
    check("rst ip_mask", 32'(ip_mask), 32'd0);
    check("rst ip_itemid", 32'(ip_itemid), 32'd0);
    check("rst ip_txid", 32'(ip_txid), 32'd0);
    check("rst c_data", 32'(c_data), 32'h5A);
    next_cycle();
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < 9; v++) begin
      p_srdy  = vecs[v].p_srdy;
      ip_drdy = vecs[v].ip_drdy;
      ic_srdy = vecs[v].ic_srdy;
      ic_txid = vecs[v].ic_txid;
      ic_data = vecs[v].ic_data;
      c_drdy  = vecs[v].c_drdy;
      @(negedge clk);
      check($sformatf("vec%0d ip_srdy", v), 32'(ip_srdy), 32'(vecs[v].e_ip_srdy));
      check($sformatf("vec%0d p_drdy", v), 32'(p_drdy), 32'(vecs[v].e_p_drdy));
      check($sformatf("vec%0d c_srdy", v), 32'(c_srdy), 32'(vecs[v].e_c_srdy));
      check($sformatf("vec%0d ic_drdy", v), 32'(ic_drdy), 32'(vecs[v].e_ic_drdy));
      check($sformatf("vec%0d c_data", v), 32'(c_data), 32'(vecs[v].ic_data));
      if (vecs[v].e_ip_srdy) begin
        exp_id = vecs[v].e_txid;
        check($sformatf("vec%0d ip_txid", v), 32'(ip_txid), 32'(exp_id));
        check($sformatf("vec%0d ip_data", v), 32'(ip_data), 32'(exp_data(exp_id)));
        check($sformatf("vec%0d ip_itemid", v), 32'(ip_itemid), 32'(exp_itemid(exp_id)));
        check($sformatf("vec%0d ip_req_type", v), 32'(ip_req_type), 32'(req_type_v[exp_id]));
        check($sformatf("vec%0d ip_mask", v), 32'(ip_mask), 32'hFF);
      end
      next_cycle();
    end
    ic_srdy = 1'b0;
    c_drdy  = '0;

    // ---------------- masked write on client 2, lock and protocol error ----------------
    do_reset();
    p_mask[2*width +: width] = 8'h0F;
    p_srdy  = 4'b0100;
    ip_drdy = 1'b0;
    @(negedge clk);
    check("mw c1 ip_txid", 32'(ip_txid), 32'd2);
    check("mw c1 p_drdy", 32'(p_drdy), 32'd0);
    check("mw c1 ip_mask", 32'(ip_mask), 32'h0F);
    next_cycle();
    // client 2 drops its request while locked: port idles, lock is kept
    p_srdy  = 4'b0001;
    ip_drdy = 1'b1;
    @(negedge clk);
    check("mw drop ip_srdy", 32'(ip_srdy), 32'd0);
    check("mw drop p_drdy", 32'(p_drdy), 32'd0);
    next_cycle();
    p_srdy  = 4'b0101;
    ip_drdy = 1'b1;
    @(negedge clk);
    check("mw c2 ip_txid", 32'(ip_txid), 32'd2);
    check("mw c2 p_drdy", 32'(p_drdy), 32'b0100);
    check("mw c2 ip_mask", 32'(ip_mask), 32'h0F);
    next_cycle();
    p_srdy = 4'b0001;
    @(negedge clk);
    check("mw c3 ip_txid", 32'(ip_txid), 32'd0);
    check("mw c3 p_drdy", 32'(p_drdy), 32'b0001);
    next_cycle();
    p_mask[2*width +: width] = 8'hFF;

    // ---------------- all four requesting, ip_drdy held high ----------------
    do_reset();
    p_srdy  = 4'b1111;
    ip_drdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef SDLIB_SCBARB_RR_EN
      exp_id = 2'(k % 4);
`else
      exp_id = 2'd0;
`endif
      @(negedge clk);
      check($sformatf("arb%0d ip_txid", k), 32'(ip_txid), 32'(exp_id));
      check($sformatf("arb%0d p_drdy", k), 32'(p_drdy), 32'(4'b0001 << exp_id));
      next_cycle();
    end
    p_srdy  = '0;
    ip_drdy = 1'b0;

    // ---------------- result backpressure on client 3 ----------------
    ic_srdy = 1'b1;
    ic_txid = 2'd3;
    ic_data = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      c_drdy = (k == 2) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      check($sformatf("bp%0d c_srdy", k), 32'(c_srdy), 32'b1000);
      check($sformatf("bp%0d c_data", k), 32'(c_data), 32'hA5);
      check($sformatf("bp%0d ic_drdy", k), 32'(ic_drdy), (k == 2) ? 32'd1 : 32'd0);
      next_cycle();
    end
    ic_srdy = 1'b0;
    c_drdy  = '0;

    // ---------------- 3-client build: txid 3 is dropped, txid 2 routed ----------------
    u3_ic_srdy = 1'b1;
    u3_ic_txid = 2'd3;
    u3_c_drdy  = 3'b000;
    @(negedge clk);
    check("c3 drop ic_drdy", 32'(u3_ic_drdy), 32'd1);
    check("c3 drop c_srdy", 32'(u3_c_srdy), 32'd0);
    next_cycle();
    u3_ic_txid = 2'd2;
    u3_c_drdy  = 3'b011;
    @(negedge clk);
    check("c3 route ic_drdy", 32'(u3_ic_drdy), 32'd0);
    check("c3 route c_srdy", 32'(u3_c_srdy), 32'b100);
    next_cycle();
    u3_ic_srdy = 1'b0;

    // ---------------- reset during a lock on client 1 ----------------
    do_reset();
    p_srdy  = 4'b0001;     // accept client 0 first so a round-robin pointer moves to 1
    ip_drdy = 1'b1;
    @(negedge clk);
    check("rl pre p_drdy", 32'(p_drdy), 32'b0001);
    next_cycle();
    p_srdy  = 4'b0010;
    ip_drdy = 1'b0;
    @(negedge clk);
    check("rl lock ip_txid", 32'(ip_txid), 32'd1);
    check("rl lock p_drdy", 32'(p_drdy), 32'd0);
    next_cycle();
    reset   = 1'b1;
    p_srdy  = 4'b0011;
    ip_drdy = 1'b1;
    @(negedge clk);
    check("rl rst p_drdy", 32'(p_drdy), 32'd0);
    check("rl rst ip_srdy", 32'(ip_srdy), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rl post ip_txid", 32'(ip_txid), 32'd0);
    check("rl post p_drdy", 32'(p_drdy), 32'b0001);
    next_cycle();
    p_srdy  = '0;
    ip_drdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
